// File: rtl/window_ctrl.sv
// 3x3 window generator: rotates a raster pixel stream through four line stores
// and emits one 72-bit window per handshake. Define WINDOW_CTRL_WRAP_EN to emit edge-wrapped columns.
module window_ctrl #(
  parameter int IMAGE_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  i_pixel,
  input  logic        i_pixel_valid,
  output logic        o_in_ready,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  input  logic        i_window_ready,
  output logic        o_line_done
);

  // state | meaning
  // IDLE  | fewer than three complete lines held, no window offered
  // READ  | window at rd_sel/rd_col offered downstream

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam logic [CW-1:0] END_COL = CW'(IMAGE_WIDTH - 1);
`ifdef WINDOW_CTRL_WRAP_EN
  localparam logic [CW-1:0] LAST_RD_COL = CW'(IMAGE_WIDTH - 1);
`else
  localparam logic [CW-1:0] LAST_RD_COL = CW'(IMAGE_WIDTH - 3);
`endif

  typedef enum logic {IDLE, READ} state_t;

  state_t         state;
  logic [7:0]     line_mem [0:4*IMAGE_WIDTH-1];
  logic [CW-1:0]  wr_col;
  logic [CW-1:0]  rd_col;
  logic [1:0]     wr_sel;
  logic [1:0]     rd_sel;
  logic [2:0]     full_lines;
  logic [2:0]     full_lines_nxt;
  logic [71:0]    win_data;
  logic           accept;
  logic           line_wr_done;
  logic           handshake;
  logic           row_done;

  assign o_in_ready   = (full_lines != 3'd4);
  assign accept       = i_pixel_valid && o_in_ready;
  assign line_wr_done = accept && (wr_col == END_COL);
  assign handshake    = o_window_valid && i_window_ready;
  assign row_done     = handshake && (rd_col == LAST_RD_COL);

  // A line completing while a row retires leaves the count unchanged.
  always_comb begin
    full_lines_nxt = full_lines;
    if (line_wr_done && !row_done)
      full_lines_nxt = full_lines + 3'd1;
    else if (!line_wr_done && row_done)
      full_lines_nxt = full_lines - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (accept)
      line_mem[{wr_sel, wr_col}] <= i_pixel;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_col <= '0;
      wr_sel <= '0;
    end else if (accept) begin
      if (wr_col == END_COL) begin
        wr_col <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  // Row and column offsets wrap naturally through the 2-bit select and CW-bit column.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_data[71 - 24*r - 8*c -: 8] = line_mem[{rd_sel + 2'(r), rd_col + CW'(c)}];
  end

  assign o_window = o_window_valid ? win_data : '0;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state          <= IDLE;
      o_window_valid <= 1'b0;
      o_line_done    <= 1'b0;
      rd_col         <= '0;
      rd_sel         <= '0;
      full_lines     <= '0;
    end else begin
      full_lines  <= full_lines_nxt;
      o_line_done <= row_done;
      case (state)
        IDLE: begin
          if (full_lines >= 3'd3) begin
            state          <= READ;
            o_window_valid <= 1'b1;
          end
        end
        READ: begin
          if (handshake) begin
            if (row_done) begin
              rd_col <= '0;
              rd_sel <= rd_sel + 2'd1;
              if (full_lines_nxt < 3'd3) begin
                state          <= IDLE;
                o_window_valid <= 1'b0;
              end
            end else begin
              rd_col <= rd_col + CW'(1);
            end
          end
        end
        default: begin
          state          <= IDLE;
          o_window_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl at W=8, pixel = row*16 + col.
// Build with WINDOW_CTRL_WRAP_EN defined to check the wrapped-column variant.
module tb_window_ctrl;

  localparam int W = 8;
`ifdef WINDOW_CTRL_WRAP_EN
  localparam int NW = W;
`else
  localparam int NW = W - 2;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  i_pixel;
  logic        i_pixel_valid;
  logic        o_in_ready;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        i_window_ready;
  logic        o_line_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [71:0] got_win [0:W-1];

  always #5 clk = ~clk;

  window_ctrl #(.IMAGE_WIDTH(W)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .o_in_ready     (o_in_ready),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .i_window_ready (i_window_ready),
    .o_line_done    (o_line_done)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [71:0] exp_win(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = {w[63:0], pix(row + r, (col + c) % W)};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    i_pixel = '0;
    i_pixel_valid = 1'b0;
    i_window_ready = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic send_pixels(input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      i_pixel = pix(row, c);
      i_pixel_valid = 1'b1;
      tick();
    end
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!o_window_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", 72'(o_window_valid), 72'(1));
  endtask

  // Drains one output row; optionally withholds ready for stall_len cycles at window stall_at.
  task automatic collect(input int row, input int n_exp, input int stall_at, input int stall_len);
    int k = 0;
    int held = 0;
    int guard = 0;
    while (k < n_exp && guard < 64) begin
      guard++;
      if (o_window_valid) begin
        if (k == stall_at && held < stall_len) begin
          i_window_ready = 1'b0;
          held++;
          check($sformatf("hold_r%0d_w%0d", row, k), o_window, exp_win(row, k));
        end else begin
          i_window_ready = 1'b1;
          check($sformatf("win_r%0d_w%0d", row, k), o_window, exp_win(row, k));
          got_win[k] = o_window;
          k++;
        end
      end else begin
        i_window_ready = 1'b1;
      end
      tick();
    end
    check($sformatf("win_count_r%0d", row), 72'(k), 72'(n_exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random inputs
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_pixel = 8'($urandom);
      i_pixel_valid = 1'($urandom);
      i_window_ready = 1'($urandom);
      tick();
    end
    check("rst_in_ready", 72'(o_in_ready), 72'(1));
    check("rst_valid", 72'(o_window_valid), 72'(0));
    check("rst_line_done", 72'(o_line_done), 72'(0));
    check("rst_window", o_window, 72'h0);

    // Basic fill and read
    do_reset();
    i_window_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_pixels(r, 0, W - 1);
    check("valid_early", 72'(o_window_valid), 72'(0));
    tick();
    check("valid_rise", 72'(o_window_valid), 72'(1));
    check("first_window", o_window, 72'h000102_101112_202122);
    collect(0, NW, -1, 0);
    check("line_done_hi", 72'(o_line_done), 72'(1));
    check("idle_after_row", 72'(o_window_valid), 72'(0));
    check("idle_window_zero", o_window, 72'h0);
    tick();
    check("line_done_lo", 72'(o_line_done), 72'(0));
    check("no_extra_window", 72'(o_window_valid), 72'(0));
`ifdef WINDOW_CTRL_WRAP_EN
    check("wrap_window6", got_win[6], 72'h060700_161710_262720);
    check("wrap_window7", got_win[7], 72'h070001_171011_272021);
`else
    check("window5", got_win[5], 72'h050607_151617_252627);
`endif

    // Backpressure at window 2
    do_reset();
    i_window_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_pixels(r, 0, W - 1);
    wait_valid(10);
    collect(0, NW, 2, 5);
    check("bp_window2", got_win[2], 72'h020304_121314_222324);
    check("bp_line_done", 72'(o_line_done), 72'(1));

    // Full stall: four rows with ready low
    do_reset();
    i_window_ready = 1'b0;
    for (int r = 0; r < 3; r++) send_pixels(r, 0, W - 1);
    send_pixels(3, 0, W - 2);
    check("in_ready_before_full", 72'(o_in_ready), 72'(1));
    send_pixels(3, W - 1, W - 1);
    check("in_ready_fall", 72'(o_in_ready), 72'(0));
    for (int c = 0; c < W; c++) begin
      i_pixel = pix(4, c);
      i_pixel_valid = 1'b1;
      tick();
    end
    i_pixel_valid = 1'b0;
    check("in_ready_stalled", 72'(o_in_ready), 72'(0));
    check("stall_window", o_window, exp_win(0, 0));
    collect(0, NW, -1, 0);
    check("stall_line_done", 72'(o_line_done), 72'(1));
    check("in_ready_return", 72'(o_in_ready), 72'(1));
    check("stall_read_continues", 72'(o_window_valid), 72'(1));
    check("stall_next_window", o_window, exp_win(1, 0));
    collect(1, NW, -1, 0);
    check("stall_idle", 72'(o_window_valid), 72'(0));
    send_pixels(4, 0, W - 1);
    wait_valid(10);
    collect(2, NW, -1, 0);
    check("stall_final_line_done", 72'(o_line_done), 72'(1));

`ifndef WINDOW_CTRL_WRAP_EN
    // Row 3 completes on the same edge as the final handshake of row 0
    do_reset();
    i_window_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_pixels(r, 0, W - 1);
    for (int i = 0; i < 8; i++) begin
      if (i >= 1)
        check($sformatf("sim_w_i%0d", i), o_window, exp_win(0, (i <= 2) ? 0 : i - 2));
      i_pixel = pix(3, i);
      i_pixel_valid = 1'b1;
      i_window_ready = (i != 1);
      tick();
    end
    i_pixel_valid = 1'b0;
    check("sim_line_done", 72'(o_line_done), 72'(1));
    check("sim_full_lines", 72'(dut.full_lines), 72'(3));
    check("sim_still_valid", 72'(o_window_valid), 72'(1));
    check("sim_next_window", o_window, 72'h101112_202122_303132);
    collect(1, NW, -1, 0);
    check("sim_idle", 72'(o_window_valid), 72'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
